// File: rtl/counter_clear_up_pkg.sv
// counter_clear_up_pkg: width helper shared by the counter and its users
package counter_clear_up_pkg;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/counter_clear_up.sv
// counter_clear_up: registered up-counter with same-cycle clear; clear+up restarts at 1
module counter_clear_up
  import counter_clear_up_pkg::*;
#(
  parameter int max_val_p = -1,
  parameter int init_val_p = -1,
  parameter bit disable_overflow_warning_p = 1'b0,
  localparam int ptr_width_lp = safe_clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);
  if (max_val_p < 0 || init_val_p < 0 || init_val_p > max_val_p) begin : g_bad_params
    $error("counter_clear_up: max_val_p/init_val_p unset or init_val_p > max_val_p");
  end
  logic [ptr_width_lp-1:0] count_n;
  always_comb count_n = clear_i ? ptr_width_lp'(up_i) : count_o + ptr_width_lp'(up_i);
  always_ff @(posedge clk_i)
    if (reset_i) count_o <= ptr_width_lp'(init_val_p);
    else count_o <= count_n;
  // non-fatal monitor: incrementing at max_val_p wraps or leaves the legal range
  always_ff @(posedge clk_i)
    if (!disable_overflow_warning_p && !reset_i && up_i && !clear_i
        && count_o == ptr_width_lp'(max_val_p))
      $warning("%m: counter overflow at max_val_p=%0d", max_val_p);
endmodule

// File: tb/tb_counter_clear_up.sv
// tb_counter_clear_up: table vectors, self-clear sequence and random run against a rule model
module tb_counter_clear_up;
  typedef struct {
    logic       rst;
    logic       clr;
    logic       up;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset, clear, up, data;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic clear_c, up_c;
  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  counter_clear_up #(.max_val_p(15), .init_val_p(3), .disable_overflow_warning_p(1'b0)) dut_a (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .up_i(up), .count_o(cnt_a));
  counter_clear_up #(.max_val_p(15), .init_val_p(3), .disable_overflow_warning_p(1'b1)) dut_b (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .up_i(up), .count_o(cnt_b));
  counter_clear_up #(.max_val_p(15), .init_val_p(0), .disable_overflow_warning_p(1'b0)) dut_c (
    .clk_i(clk), .reset_i(1'b0), .clear_i(clear_c), .up_i(up_c), .count_o(cnt_c));

  assign clear_c = data | cnt_c[3];
  assign up_c = ~data;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic u, input int e);
    vec_t v;
    v.rst = r; v.clr = c; v.up = u; v.exp = 4'(e);
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic c, input logic u);
    @(negedge clk);
    reset = r; clear = c; up = u;
    @(posedge clk);
    #1;
  endtask

  // next count from the stated rules, in plain integer arithmetic
  function automatic int model(input int cur, input logic r, input logic c, input logic u);
    if (r) return 3;
    if (c) return u ? 1 : 0;
    if (u) return (cur + 1) % 16;
    return cur;
  endfunction

  initial begin
    int m;
    reset = 1'b0; clear = 1'b0; up = 1'b0; data = 1'b1;
    add(1, 0, 0, 3);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 3);
    for (int i = 4; i <= 7; i++) add(0, 0, 1, i);
    add(0, 0, 0, 7);
    add(0, 1, 0, 0);
    add(0, 1, 1, 1);
    for (int i = 2; i <= 15; i++) add(0, 0, 1, i);
    add(0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) add(0, 0, 1, i);
    add(1, 1, 1, 3);
    add(0, 0, 0, 3);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].up);
      check($sformatf("vec%0d_a", i), cnt_a, vecs[i].exp);
      check($sformatf("vec%0d_b", i), cnt_b, vecs[i].exp);
    end

    // self-clearing detector: data=1 initialises, then run of zeros
    @(negedge clk); data = 1'b1;
    @(posedge clk); #1;
    check("selfclr_init", cnt_c, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); data = 1'b0;
      @(posedge clk); #1;
      check($sformatf("selfclr_zero%0d", i), cnt_c, 4'(i));
    end
    @(posedge clk); #1;
    check("selfclr_restart", cnt_c, 4'd1);
    @(negedge clk); data = 1'b1;
    @(posedge clk); #1;
    check("selfclr_one", cnt_c, 4'd0);

    m = 32'(cnt_a);
    for (int i = 0; i < 300; i++) begin
      logic r, c, u;
      r = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 5) == 0);
      u = 1'($urandom);
      step(r, c, u);
      m = model(m, r, c, u);
      check($sformatf("rand%0d_a", i), cnt_a, 4'(m));
      check($sformatf("rand%0d_b", i), cnt_b, 4'(m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
